// File: rtl/tone_gen.sv
// tone_gen: note-driven tone generator feeding an N-bit PWM DAC.
// Notes (frequency word, duration in frames, waveform) arrive over a
// valid/ready handshake. A phase accumulator produces square, saw or triangle
// samples. The sample register only changes on PWM frame boundaries
// (one frame = 2^N clocks), so the DAC never sees a mid-period change.
// Optional feature macro: TONE_GEN_ENVELOPE_EN (decaying amplitude envelope).
module tone_gen #(
  parameter int N            = 8,
  parameter int PHASE_W      = 16,
  parameter int DUR_W        = 12,
  parameter int DECAY_FRAMES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [PHASE_W-1:0] note_freq,
  input  logic [DUR_W-1:0]   note_dur,
  input  logic [1:0]         note_wave,
  input  logic               stop,
  output logic [N-1:0]       sample,
  output logic               busy,
  output logic               note_done
);

  localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       frame_ctr_q;
  logic               frame_tick_s;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] freq_q, freq_d;
  logic [1:0]         wave_q, wave_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [N-1:0]       sample_q, sample_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [N-1:0]       wave_s;

  // Parameter sets the datapath cannot represent elaborate this marker block.
  if (PHASE_W < N || DECAY_FRAMES < 1 || N < 2) begin : g_bad_params
  end

  // Waveform lookup from the top N phase bits.
  function automatic logic [N-1:0] wave_fn(input logic [1:0] wave,
                                           input logic [PHASE_W-1:0] ph);
    logic [N-1:0] p;
    logic [N-1:0] tri_v;
    p     = ph[PHASE_W-1 -: N];
    tri_v = {p[N-2:0], 1'b0};
    case (wave)
      2'b00:   wave_fn = p[N-1] ? {N{1'b1}} : {N{1'b0}};
      2'b01:   wave_fn = p;
      2'b10:   wave_fn = p[N-1] ? ~tri_v : tri_v;
      default: wave_fn = MID;
    endcase
  endfunction

`ifdef TONE_GEN_ENVELOPE_EN
  localparam int AW = $clog2(N);
  localparam int DW = $clog2(DECAY_FRAMES + 1);

  logic [AW-1:0] atten_q, atten_d;
  logic [DW-1:0] decay_q, decay_d;
  logic [DW-1:0] decay_inc_s;

  // Arithmetic shift of the signed excursion around MID.
  function automatic logic [N-1:0] env_scale(input logic [N-1:0] w,
                                             input logic [AW-1:0] sh);
    logic signed [N:0] diff;
    diff = $signed({1'b0, w}) - $signed({1'b0, MID});
    diff = diff >>> sh;
    return MID + diff[N-1:0];
  endfunction

  assign decay_inc_s = decay_q + DW'(1);
`endif

  assign frame_tick_s = &frame_ctr_q;
  assign wave_s       = wave_fn(wave_q, phase_q);

  assign note_ready = ready_q;
  assign busy       = busy_q;
  assign note_done  = done_q;
  assign sample     = sample_q;

  // Next-state logic: handshake, frame-aligned sample updates, note end/stop.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    freq_d   = freq_q;
    wave_d   = wave_q;
    rem_d    = rem_q;
    sample_d = sample_q;
    done_d   = 1'b0;
`ifdef TONE_GEN_ENVELOPE_EN
    atten_d  = atten_q;
    decay_d  = decay_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sample_d = MID;
        if (note_valid && ready_q) begin
          freq_d  = note_freq;
          rem_d   = note_dur;
          wave_d  = note_wave;
          phase_d = {PHASE_W{1'b0}};
          if (note_dur != {DUR_W{1'b0}}) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (frame_tick_s && stop) begin
          sample_d = MID;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (frame_tick_s) begin
          // phase_q is zero here (cleared on accept), so wave_s is W(0)
          sample_d = wave_s;
          phase_d  = freq_q;
          rem_d    = rem_q - DUR_W'(1);
          state_d  = ST_PLAY;
`ifdef TONE_GEN_ENVELOPE_EN
          atten_d  = {AW{1'b0}};
          decay_d  = {DW{1'b0}};
`endif
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_PLAY: begin
        if (frame_tick_s && (stop || rem_q == {DUR_W{1'b0}})) begin
          sample_d = MID;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (frame_tick_s) begin
`ifdef TONE_GEN_ENVELOPE_EN
          if (decay_inc_s == DW'(DECAY_FRAMES)) begin
            decay_d = {DW{1'b0}};
            if (atten_q != AW'(N - 1)) begin
              atten_d = atten_q + AW'(1);
            end else begin
              atten_d = atten_q;
            end
          end else begin
            decay_d = decay_inc_s;
            atten_d = atten_q;
          end
          sample_d = env_scale(wave_s, atten_d);
`else
          sample_d = wave_s;
`endif
          phase_d = phase_q + freq_q;
          rem_d   = rem_q - DUR_W'(1);
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        sample_d = MID;
        state_d  = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; frame counter free-runs aligned with the DAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      frame_ctr_q <= {N{1'b0}};
      phase_q     <= {PHASE_W{1'b0}};
      freq_q      <= {PHASE_W{1'b0}};
      wave_q      <= 2'b00;
      rem_q       <= {DUR_W{1'b0}};
      sample_q    <= MID;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef TONE_GEN_ENVELOPE_EN
      atten_q     <= {AW{1'b0}};
      decay_q     <= {DW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      frame_ctr_q <= frame_ctr_q + N'(1);
      phase_q     <= phase_d;
      freq_q      <= freq_d;
      wave_q      <= wave_d;
      rem_q       <= rem_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef TONE_GEN_ENVELOPE_EN
      atten_q     <= atten_d;
      decay_q     <= decay_d;
`endif
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen (default build): directed and random notes checked
// frame by frame against a per-note sample-sequence model.
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        note_valid;
  logic        note_ready;
  logic [15:0] note_freq;
  logic [11:0] note_dur;
  logic [1:0]  note_wave;
  logic        stop;
  logic [7:0]  sample;
  logic        busy;
  logic        note_done;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;   // clock edges since last reset release == frame_ctr (mod 256)

  tone_gen #(.N(8), .PHASE_W(16), .DUR_W(12), .DECAY_FRAMES(16)) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_freq(note_freq), .note_dur(note_dur), .note_wave(note_wave),
    .stop(stop), .sample(sample), .busy(busy), .note_done(note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame f of a note plays phase f*freq; sample is a function of its top byte.
  function automatic int model_w(input int wave, input int freq, input int f);
    int ph;
    int p;
    ph = (f * freq) % 65536;
    p  = ph / 256;
    case (wave)
      0:       return (p >= 128) ? 255 : 0;
      1:       return p;
      2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return 128;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic play_note(input int freq, input int dur, input int wave,
                           input int stop_f, input bit bogus, input bit align);
    int errs;
    int accept;
    int first_tick;
    int end_f;
    int tick_e;
    int stop_e;
    int nxt;
    int gap;
    int e;
    logic [7:0] cur;
    errs = 0;
    if (align) begin
      while ((ecnt + 1) % 256 != 0) begin
        step();
        if (sample !== 8'h80 || busy !== 1'b0 || note_done !== 1'b0 || note_ready !== 1'b1) errs++;
      end
    end else begin
      gap = $urandom_range(1, 300);
      for (int i = 0; i < gap; i++) begin
        step();
        if (sample !== 8'h80 || busy !== 1'b0 || note_done !== 1'b0 || note_ready !== 1'b1) errs++;
      end
    end
    chk("idle_gap", 32'(errs), 32'd0);

    note_valid = 1'b1;
    note_freq  = 16'(freq);
    note_dur   = 12'(dur);
    note_wave  = 2'(wave);
    step();
    accept = ecnt;
    if (bogus) begin
      note_freq = ~note_freq;
      note_dur  = 12'd1;
      note_wave = note_wave ^ 2'b01;
    end else begin
      note_valid = 1'b0;
    end

    if (dur == 0) begin
      note_valid = 1'b0;
      chk("dur0_busy", 32'(busy), 32'd0);
      chk("dur0_ready", 32'(note_ready), 32'd1);
      errs = 0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (busy !== 1'b0 || note_done !== 1'b0 || sample !== 8'h80) errs++;
      end
      chk("dur0_quiet", 32'(errs), 32'd0);
      return;
    end

    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_ready", 32'(note_ready), 32'd0);
    first_tick = (accept / 256 + 1) * 256;
    end_f  = (stop_f >= 0 && stop_f < dur) ? stop_f : dur;
    stop_e = first_tick + 256 * stop_f;
    cur    = 8'h80;
    for (int f = 0; f <= end_f; f++) begin
      tick_e = first_tick + 256 * f;
      errs   = 0;
      while (ecnt < tick_e) begin
        nxt = ecnt + 1;
        if (nxt >= first_tick) note_valid = 1'b0;
        stop = (stop_f >= 0) && (nxt >= stop_e - 2) && (nxt <= stop_e + 1);
        step();
        if (ecnt < tick_e) begin
          if (sample !== cur || note_done !== 1'b0 || busy !== 1'b1) errs++;
        end
      end
      chk("frame_hold", 32'(errs), 32'd0);
      if (f == end_f) begin
        chk("end_sample", 32'(sample), 32'h80);
        chk("end_done", 32'(note_done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(note_ready), 32'd1);
      end else begin
        e = model_w(wave, freq, f);
        chk("frame_sample", 32'(sample), 32'(e));
        chk("frame_done", 32'(note_done), 32'd0);
        cur = 8'(e);
      end
    end
    stop = 1'b0;
    step();
    chk("done_pulse", 32'(note_done), 32'd0);
    chk("post_sample", 32'(sample), 32'h80);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int fr;
    int d;
    int sf;
    reset      = 1'b0;
    note_valid = 1'b0;
    note_freq  = 16'h0000;
    note_dur   = 12'h000;
    note_wave  = 2'b00;
    stop       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sample", 32'(sample), 32'h80);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(note_done), 32'd0);
    chk("rst_ready", 32'(note_ready), 32'd0);
    reset = 1'b1;
    ecnt  = 0;
    #2;
    chk("rel_ready", 32'(note_ready), 32'd0);
    step();
    chk("ready_rise", 32'(note_ready), 32'd1);

    play_note(32'h8000, 4, 0, -1, 1'b0, 1'b0);   // square
    play_note(32'h1000, 3, 1, -1, 1'b0, 1'b0);   // saw
    play_note(32'h4000, 4, 2, -1, 1'b0, 1'b0);   // triangle
    play_note(32'h1234, 2, 3, -1, 1'b0, 1'b0);   // silence
    play_note(32'h8000, 100, 0, 10, 1'b1, 1'b0); // stop mid-note, note offered while busy
    play_note(32'h8000, 0, 0, -1, 1'b0, 1'b0);   // zero duration
    play_note(32'h2000, 3, 1, 3, 1'b0, 1'b0);    // stop coincides with normal end
    play_note(32'h3000, 2, 2, 0, 1'b0, 1'b0);    // stop while armed
    play_note(32'h0800, 2, 1, -1, 1'b0, 1'b1);   // accepted on a frame_tick edge

    for (int n = 0; n < 10; n++) begin
      w  = $urandom_range(0, 3);
      fr = $urandom & 32'hFFFF;
      d  = $urandom_range(1, 6);
      sf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d) : -1;
      play_note(fr, d, w, sf, 1'(($urandom_range(0, 1))), ($urandom_range(0, 4) == 0));
    end

    // Reset asserted mid-note: immediate return to reset values.
    note_valid = 1'b1;
    note_freq  = 16'h8000;
    note_dur   = 12'd50;
    note_wave  = 2'b00;
    step();
    note_valid = 1'b0;
    repeat (600) step();
    reset = 1'b0;
    #2;
    chk("mid_rst_sample", 32'(sample), 32'h80);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(note_ready), 32'd0);
    chk("mid_rst_done", 32'(note_done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold_done", 32'(note_done), 32'd0);
    reset = 1'b1;
    ecnt  = 0;
    step();
    chk("mid_rst_ready_rise", 32'(note_ready), 32'd1);
    play_note(32'h1000, 3, 1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
Sample source directly upstream of the N-bit PWM DAC; its sample output drives the DAC on-time input.
- Accepts notes over a valid/ready handshake. Each note carries a frequency word, a duration in frames and a waveform select.
- Generates square, saw or triangle samples with a phase accumulator.
- Updates its sample only at PWM frame boundaries, one frame being 2^N clocks. The DAC therefore never sees a mid-period change.

Parameters:
N, 8, sample width; must equal the DAC width.
PHASE_W, 16, phase accumulator and frequency word width; must be greater than or equal to N.
DUR_W, 12, note duration counter width, in frames.
DECAY_FRAMES, 16, frames per envelope attenuation step (ENVELOPE_EN only).

Ports:
clk  in  1  clock.
reset  in  1  reset. One clock; reset is asynchronous and active-low.
note_valid  in  1  note offered.
note_ready  out  1  block can accept a note.
note_freq  in  PHASE_W  phase increment per frame.
note_dur  in  DUR_W  note length in frames.
note_wave  in  2  waveform: 00 square, 01 saw, 10 triangle, 11 silence.
stop  in  1  abort the current note.
sample  out  N  sample to the DAC on-time input.
busy  out  1  high while a note is armed or playing.
note_done  out  1  one-cycle pulse when a note ends.

Behaviour:
Reset values (reset low):
- state IDLE, sample = MID = 2^(N-1), frame_ctr = 0, phase = 0.
- note_ready = 0, busy = 0, note_done = 0.
- note_ready is registered and goes to 1 on the first clk edge after reset release.

Frame timing:
- frame_ctr is N bits, free-running, +1 per clk, wraps from 2^N-1 to 0.
- frame_tick = (frame_ctr == 2^N-1). It is aligned with the DAC counter because both reset together.
- sample changes only on clk edges where frame_tick = 1.

States: IDLE, ARMED, PLAY.
- note_ready = 1 only in IDLE. busy = 1 in ARMED or PLAY.

IDLE:
- sample held at MID.
- Transfer occurs when note_valid and note_ready are both high on a clk edge.
- On transfer: latch freq, dur and wave; clear phase.
- If dur = 0: consume the note and stay in IDLE, with no busy and no note_done.
- Otherwise: go to ARMED; note_ready drops the next cycle.

ARMED:
- Wait for frame_tick.
- On frame_tick: sample = W(phase = 0), phase = freq, rem = dur-1, go to PLAY.

PLAY, on each frame_tick:
- If rem = 0: sample = MID, pulse note_done, go to IDLE.
- Else: sample = W(phase), phase += freq (mod 2^PHASE_W), rem -= 1.
- A note therefore outputs exactly dur frames.

Waveform W, with p = phase[PHASE_W-1 : PHASE_W-N]:
- square: p[N-1] ? 2^N-1 : 0.
- saw: p.
- triangle: p[N-1] ? ~{p[N-2:0],0} : {p[N-2:0],0}.
- silence: MID.

stop:
- Sampled on clk edges; effective when stop is high on the frame_tick edge while in ARMED or PLAY.
- Effect: sample = MID, pulse note_done, go to IDLE.
- Ignored in IDLE.
- stop coinciding with normal note end: exactly one note_done pulse.

Other boundaries:
- note_valid while busy: not accepted; inputs are not latched.
- Reset asserted mid-note: immediate return to reset values, with no note_done pulse.
- A note accepted on a frame_tick edge waits for the next frame_tick.

Optional Feature:
Macro: TONE_GEN_ENVELOPE_EN.
Defined:
- Attenuation register atten, width clog2(N), cleared at PLAY entry.
- atten increments every DECAY_FRAMES frame_ticks in PLAY and saturates at N-1.
- sample = MID + ((W - MID) as a signed N+1-bit value >>> atten).
Undefined:
- atten logic absent; sample = W unscaled.

Test Plan:
1. Reset low 5 clks then release -> sample = 0x80, busy = 0, note_done = 0; note_ready = 0 until 1 clk after release, then 1.
2. Square, freq 0x8000, dur 4 (N=8) -> per frame: 0x00, 0xFF, 0x00, 0xFF, then 0x80 with a one-cycle note_done. Changes occur only on edges where frame_ctr = 255.
3. Saw, freq 0x1000, dur 3 -> frames 0x00, 0x10, 0x20, then 0x80. busy is high from the accept edge to the done edge.
4. Triangle, freq 0x4000, dur 4 -> frames 0x00, 0x80, 0xFF, 0x7F, then 0x80.
5. Square dur 100 with stop pulsed high across the frame_tick edge of frame 10 -> next tick gives 0x80, a single note_done, note_ready = 1. A note_valid offered during the note is not accepted.
6. dur = 0 offered -> accepted, busy stays 0, no note_done, sample stays 0x80. With TONE_GEN_ENVELOPE_EN and DECAY_FRAMES = 2, square freq 0x8000 -> amplitude halves every 2 frames: 0x00/0xFF, then 0x40/0xBF, and so on.
